ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus operand forwarding and load-use detection, directly upstream of the ALU.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/fwd_sel.sv | 32 +++
 rtl/ex_operand_stage.sv | 133 +++++++++++++
 tb/tb_ex_operand_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared datapath widths, ALU control codes and forwarding select codes
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CTL_W_DEF  = 5;

  // ALUCt encoding; AND is all-zero so a bubble carries a harmless operation
  localparam logic [4:0] ALUCT_AND = 5'd0;
  localparam logic [4:0] ALUCT_OR  = 5'd1;
  localparam logic [4:0] ALUCT_ADD = 5'd2;
  localparam logic [4:0] ALUCT_SLL = 5'd3;
  localparam logic [4:0] ALUCT_SRL = 5'd4;
  localparam logic [4:0] ALUCT_SRA = 5'd5;
  localparam logic [4:0] ALUCT_SUB = 5'd6;
  localparam logic [4:0] ALUCT_SLT = 5'd7;
  localparam logic [4:0] ALUCT_NOR = 5'd12;
  localparam logic [4:0] ALUCT_XOR = 5'd13;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_e;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - bypass source selection for one EX-stage source operand
module fwd_sel
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic              exmem_regwr,
  input  logic [REG_AW-1:0] exmem_dst,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwr,
  input  logic [REG_AW-1:0] memwb_dst,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] byp_data,
  output fwd_e              sel
);

  // Youngest producer wins; $0 is hardwired so it is never bypassed
  always_comb begin
    sel      = FWD_NONE;
    byp_data = '0;
    if (exmem_regwr && (exmem_dst != '0) && (exmem_dst == src)) begin
      sel      = FWD_EXMEM;
      byp_data = exmem_result;
    end else if (memwb_regwr && (memwb_dst != '0) && (memwb_dst == src)) begin
      sel      = FWD_MEMWB;
      byp_data = memwb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with operand forwarding and load-use detection
module ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CTL_W  = CTL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic [CTL_W-1:0]  id_aluct,
  input  logic              id_sign,
  input  logic              id_alusrc,
  input  logic              id_memrd,
  input  logic              id_memwr,
  input  logic              id_regwr,
  input  logic              id_memtoreg,
  input  logic              exmem_regwr,
  input  logic [REG_AW-1:0] exmem_dst,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwr,
  input  logic [REG_AW-1:0] memwb_dst,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [CTL_W-1:0]  alu_ct,
  output logic              alu_sign,
  output logic [4:0]        alu_shamt,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dst,
  output logic              ex_valid,
  output logic              ex_memrd,
  output logic              ex_memwr,
  output logic              ex_regwr,
  output logic              ex_memtoreg,
  output logic              load_use_stall
);

  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt;
  logic              ex_alusrc;
  logic [DATA_W-1:0] rs_byp, rt_byp, fwd_rs, fwd_rt;
  fwd_e              rs_sel, rt_sel;

  // A load in EX cannot bypass to the instruction in ID; the rt check also
  // covers a store's data operand, which reads rt even though alusrc is set
  always_comb begin
    load_use_stall = ex_valid && ex_memrd && (ex_dst != '0) && id_valid &&
                     ((ex_dst == id_rs) ||
                      ((ex_dst == id_rt) && (!id_alusrc || id_memwr)));
  end

  // Pipeline register: reset/flush/load-use bubble clear, stall holds, else capture
  always_ff @(posedge clk) begin
    if (reset || flush || load_use_stall) begin
      ex_valid    <= 1'b0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      alu_shamt   <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dst      <= '0;
      alu_ct      <= CTL_W'(ALUCT_AND);
      alu_sign    <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memrd    <= 1'b0;
      ex_memwr    <= 1'b0;
      ex_regwr    <= 1'b0;
      ex_memtoreg <= 1'b0;
    end else if (!stall) begin
      ex_valid    <= id_valid;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      alu_shamt   <= id_shamt;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_dst      <= id_dst;
      alu_ct      <= id_aluct;
      alu_sign    <= id_sign;
      ex_alusrc   <= id_alusrc;
      ex_memrd    <= id_memrd;
      ex_memwr    <= id_memwr;
      ex_regwr    <= id_regwr;
      ex_memtoreg <= id_memtoreg;
    end
  end

  fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src          (ex_rs),
    .exmem_regwr  (exmem_regwr),
    .exmem_dst    (exmem_dst),
    .exmem_result (exmem_result),
    .memwb_regwr  (memwb_regwr),
    .memwb_dst    (memwb_dst),
    .memwb_data   (memwb_data),
    .byp_data     (rs_byp),
    .sel          (rs_sel)
  );

  fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src          (ex_rt),
    .exmem_regwr  (exmem_regwr),
    .exmem_dst    (exmem_dst),
    .exmem_result (exmem_result),
    .memwb_regwr  (memwb_regwr),
    .memwb_dst    (memwb_dst),
    .memwb_data   (memwb_data),
    .byp_data     (rt_byp),
    .sel          (rt_sel)
  );

  // Operand muxing: register-file value unless a later stage supplies a newer one
  always_comb begin
    fwd_rs        = (rs_sel == FWD_NONE) ? ex_rs_data : rs_byp;
    fwd_rt        = (rt_sel == FWD_NONE) ? ex_rt_data : rt_byp;
    alu_in1       = fwd_rs;
    alu_in2       = ex_alusrc ? ex_imm : fwd_rt;
    ex_store_data = fwd_rt;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_dst, id_aluct;
  logic        id_sign, id_alusrc, id_memrd, id_memwr, id_regwr, id_memtoreg;
  logic        exmem_regwr, memwb_regwr;
  logic [4:0]  exmem_dst, memwb_dst;
  logic [31:0] exmem_result, memwb_data;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [4:0]  alu_ct, alu_shamt, ex_dst;
  logic        alu_sign, ex_valid, ex_memrd, ex_memwr, ex_regwr, ex_memtoreg;
  logic        load_use_stall;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_aluct(id_aluct), .id_sign(id_sign), .id_alusrc(id_alusrc),
    .id_memrd(id_memrd), .id_memwr(id_memwr), .id_regwr(id_regwr),
    .id_memtoreg(id_memtoreg), .exmem_regwr(exmem_regwr), .exmem_dst(exmem_dst),
    .exmem_result(exmem_result), .memwb_regwr(memwb_regwr), .memwb_dst(memwb_dst),
    .memwb_data(memwb_data), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_ct(alu_ct), .alu_sign(alu_sign), .alu_shamt(alu_shamt),
    .ex_store_data(ex_store_data), .ex_dst(ex_dst), .ex_valid(ex_valid),
    .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_regwr(ex_regwr),
    .ex_memtoreg(ex_memtoreg), .load_use_stall(load_use_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic src, input logic mrd,
                          input logic mwr, input logic rwr, input logic [4:0] ct);
    id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alusrc = src;
    id_memrd = mrd; id_memwr = mwr; id_regwr = rwr; id_memtoreg = mrd;
    id_aluct = ct; id_sign = 1'b0; id_shamt = 5'd0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    exmem_regwr = 1'b0; exmem_dst = 5'd0; exmem_result = 32'h0;
    memwb_regwr = 1'b0; memwb_dst = 5'd0; memwb_data = 32'h0;
    #2;
    tick();
    check("rst_in1", alu_in1, 32'h0);
    check("rst_in2", alu_in2, 32'h0);
    check("rst_ct", {27'd0, alu_ct}, 32'h0);
    check("rst_dst", {27'd0, ex_dst}, 32'h0);
    check("rst_valid", {31'd0, ex_valid}, 32'h0);
    check("rst_regwr", {31'd0, ex_regwr}, 32'h0);
    check("rst_lus", {31'd0, load_use_stall}, 32'h0);
    reset = 1'b0;

    // add with rs=$3 while EX/MEM is producing $3
    drive_id(1'b1, 5'd3, 5'd2, 5'd6, 32'h111, 32'h22, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, ALUCT_ADD);
    id_shamt = 5'd7;
    exmem_regwr = 1'b1; exmem_dst = 5'd3; exmem_result = 32'h10;
    tick();
    check("exmem_fwd_in1", alu_in1, 32'h10);
    check("no_fwd_in2", alu_in2, 32'h22);
    check("ct_captured", {27'd0, alu_ct}, {27'd0, ALUCT_ADD});
    check("shamt_captured", {27'd0, alu_shamt}, 32'd7);
    check("dst_captured", {27'd0, ex_dst}, 32'd6);
    check("valid_captured", {31'd0, ex_valid}, 32'd1);

    // immediate operand with forwarded store data on rt
    drive_id(1'b1, 5'd7, 5'd5, 5'd0, 32'h77, 32'h55, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0, ALUCT_ADD);
    exmem_dst = 5'd5;
    tick();
    check("imm_in2", alu_in2, 32'h44);
    check("store_fwd", ex_store_data, 32'h10);
    check("memwr_captured", {31'd0, ex_memwr}, 32'd1);

    // both stages write $5: EX/MEM wins, then MEM/WB alone
    drive_id(1'b1, 5'd5, 5'd1, 5'd8, 32'h999, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, ALUCT_OR);
    exmem_regwr = 1'b1; exmem_dst = 5'd5; exmem_result = 32'hAAAA0000;
    memwb_regwr = 1'b1; memwb_dst = 5'd5; memwb_data = 32'h12345678;
    tick();
    check("exmem_beats_memwb", alu_in1, 32'hAAAA0000);
    exmem_regwr = 1'b0;
    #1;
    check("memwb_fwd", alu_in1, 32'h12345678);

    // $0 is never forwarded
    drive_id(1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, ALUCT_ADD);
    exmem_regwr = 1'b1; exmem_dst = 5'd0; exmem_result = 32'hFFFFFFFF;
    memwb_regwr = 1'b1; memwb_dst = 5'd0; memwb_data = 32'hFFFFFFFF;
    tick();
    check("r0_no_fwd", alu_in1, 32'h0);
    check("r0_store", ex_store_data, 32'h0);

    // lw $4 then dependent add: one bubble, then MEM/WB forward
    exmem_regwr = 1'b0; memwb_regwr = 1'b0;
    drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h100, 32'h0, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, ALUCT_ADD);
    tick();
    drive_id(1'b1, 5'd4, 5'd2, 5'd9, 32'hDEAD0000, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, ALUCT_ADD);
    #1;
    check("lu_rs_stall", {31'd0, load_use_stall}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_regwr", {31'd0, ex_regwr}, 32'd0);
    check("lu_released", {31'd0, load_use_stall}, 32'd0);
    tick();
    memwb_regwr = 1'b1; memwb_dst = 5'd4; memwb_data = 32'hCAFEF00D;
    #1;
    check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_add_fwd", alu_in1, 32'hCAFEF00D);
    check("lu_add_dst", {27'd0, ex_dst}, 32'd9);

    // rt-side load-use cases
    memwb_regwr = 1'b0;
    drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h100, 32'h0, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, ALUCT_ADD);
    tick();
    drive_id(1'b1, 5'd1, 5'd4, 5'd0, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0, ALUCT_ADD);
    #1;
    check("lu_sw_rt", {31'd0, load_use_stall}, 32'd1);
    id_memwr = 1'b0;
    #1;
    check("lu_imm_rt_none", {31'd0, load_use_stall}, 32'd0);
    id_rs = 5'd4; id_valid = 1'b0;
    #1;
    check("lu_id_invalid", {31'd0, load_use_stall}, 32'd0);

    // flush and stall together squash a valid instruction
    drive_id(1'b1, 5'd2, 5'd2, 5'd11, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, ALUCT_SUB);
    stall = 1'b1; flush = 1'b1;
    tick();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_regwr", {31'd0, ex_regwr}, 32'd0);

    // stall holds the captured instruction
    stall = 1'b0; flush = 1'b0;
    id_dst = 5'd12;
    tick();
    id_dst = 5'd13; stall = 1'b1;
    tick();
    check("stall_hold_dst", {27'd0, ex_dst}, 32'd12);
    check("stall_hold_ct", {27'd0, alu_ct}, {27'd0, ALUCT_SUB});

    // reset during a load-use stall
    stall = 1'b0;
    drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h100, 32'h0, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, ALUCT_ADD);
    tick();
    drive_id(1'b1, 5'd4, 5'd3, 5'd14, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, ALUCT_ADD);
    stall = 1'b1;
    #1;
    check("pre_rst_lus", {31'd0, load_use_stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_mid_lus", {31'd0, load_use_stall}, 32'd0);
    check("rst_mid_dst", {27'd0, ex_dst}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
